// File: rtl/uart_pkg.sv
// Shared UART definitions: rate/width defaults, FSM state encoding, parity helper.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit between data and stop).
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEF = 5208;  // 50 MHz / 9600 baud
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned BIT_CNT_W       = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4,
    PARITY = 3'd5
  } state_t;

  // Even parity: XOR of all payload bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Enable-gated bit-period counter. Counts 0..CLK_PER_BIT-1 while en is high,
// wraps to 0, and is held at 0 while en is low.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   en         count enable (frame bit in progress)
//   bit_end_c  combinational: last clock of the current bit
//   mid_bit_c  combinational: centre clock of the current bit
module uart_baud_cnt #(
  parameter int unsigned CLK_PER_BIT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit_end_c,
  output logic mid_bit_c
);

  logic [CNT_W-1:0] count;

  assign bit_end_c = en && (count == CNT_W'(CLK_PER_BIT - 1));
  assign mid_bit_c = en && (count == CNT_W'(CLK_PER_BIT / 2));

  // Bit-period counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!en || bit_end_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first. A one-cycle tx_start in IDLE captures
// data_in and sends start bit, 8 data bits and stop bit, each CLK_PER_BIT
// clocks long, followed by a one-cycle DONE with tx_done high.
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the last data bit and the stop bit.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   tx_start  send request, sampled only in IDLE
//   data_in   byte to send, captured with the accepted tx_start
//   tx        serial line (registered, idles high)
//   tx_busy   high from START through DONE
//   tx_done   one-cycle pulse at frame end
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [BIT_CNT_W-1:0] bit_counter;
  logic [BIT_CNT_W-1:0] bit_counter_next;
  logic                 tx_next;
  logic                 tx_busy_next;
  logic                 tx_done_next;
  logic                 baud_en;
  logic                 bit_end;
  logic                 baud_mid_unused;

  assign baud_en = (state == START) || (state == DATA) ||
                   (state == STOP)  || (state == PARITY);

  uart_baud_cnt #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .en        (baud_en),
    .bit_end_c (bit_end),
    .mid_bit_c (baud_mid_unused)
  );

  // State, payload and registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_counter <= '0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      bit_counter <= bit_counter_next;
      tx          <= tx_next;
      tx_busy     <= tx_busy_next;
      tx_done     <= tx_done_next;
    end
  end

  // Next-state logic, then outputs decoded from the next state so the
  // registered pins line up with the state they describe.
  always_comb begin
    state_next       = state;
    shift_next       = shift_reg;
    bit_counter_next = bit_counter;
    tx_next          = 1'b1;
    tx_busy_next     = 1'b1;
    tx_done_next     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_next = data_in;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_counter_next = '0;
          state_next       = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_counter_next = bit_counter + BIT_CNT_W'(1);
          if (bit_counter == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      IDLE:  tx_busy_next = 1'b0;
      START: tx_next      = 1'b0;
      DATA:  tx_next      = shift_next[bit_counter_next];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next     = even_parity(shift_next);
`endif
      DONE:  tx_done_next = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLK_PER_BIT=16: directed scenarios plus
// randomized bytes, checked cycle by cycle against an arithmetic frame model.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
  localparam int NBITS     = 11;
`else
  localparam bit PARITY_ON = 1'b0;
  localparam int NBITS     = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .data_in  (data_in),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PARITY_ON && idx == 9) return 1'($countones(d) % 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0d observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Call with tx_start already high and the DUT idle; the next edge accepts.
  task automatic frame_check(input logic [7:0] d, input bit hold,
                             input int intr, input logic [7:0] idata);
    @(posedge clk); #1;
    if (!hold) tx_start = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      chk("tx_bit", k, tx, frame_bit(d, k / CPB));
      chk("busy_in_frame", k, tx_busy, 1'b1);
      chk("no_early_done", k, tx_done, 1'b0);
      if (k == 0) data_in = 8'($urandom);
      if (k == intr) begin
        tx_start = 1'b1;
        data_in  = idata;
      end else if (intr >= 0 && k == intr + 1) begin
        tx_start = 1'b0;
        data_in  = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("done_pulse", FRAME_CYC, tx_done, 1'b1);
    chk("done_tx_high", FRAME_CYC, tx, 1'b1);
    chk("done_busy", FRAME_CYC, tx_busy, 1'b1);
    @(posedge clk); #1;
    chk("done_cleared", FRAME_CYC + 1, tx_done, 1'b0);
    chk("idle_busy", FRAME_CYC + 1, tx_busy, 1'b0);
    chk("idle_tx", FRAME_CYC + 1, tx, 1'b1);
  endtask

  task automatic start_req(input logic [7:0] d);
    @(negedge clk);
    tx_start = 1'b1;
    data_in  = d;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", n, tx_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] idata;
    int         gap;
    int         intr;

    reset    = 1'b0;
    tx_start = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 0, tx, 1'b1);
    chk("rst_busy", 0, tx_busy, 1'b0);
    chk("rst_done", 0, tx_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst_tx", 0, tx, 1'b1);

    // Single byte 0x55.
    start_req(8'h55);
    frame_check(8'h55, 1'b0, -1, 8'h00);

    // Back-to-back 0xA5 then 0x3C with tx_start held high.
    start_req(8'hA5);
    frame_check(8'hA5, 1'b1, -1, 8'h00);
    data_in = 8'h3C;
    frame_check(8'h3C, 1'b0, -1, 8'h00);

    // tx_start with 0x0F mid-frame is ignored.
    wait_idle(4 * FRAME_CYC);
    start_req(8'hF0);
    frame_check(8'hF0, 1'b0, 50, 8'h0F);

    // Reset mid-frame: line returns high at once, no done pulse.
    wait_idle(4 * FRAME_CYC);
    start_req(8'h00);
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("pre_rst_tx", 70, tx, 1'b0);
    chk("pre_rst_busy", 70, tx_busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_tx", 70, tx, 1'b1);
    chk("async_rst_busy", 70, tx_busy, 1'b0);
    chk("async_rst_done", 70, tx_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_done", i, tx_done, 1'b0);
      chk("rst_hold_tx", i, tx, 1'b1);
    end
    @(negedge clk);
    reset = 1'b1;
    start_req(8'h81);
    frame_check(8'h81, 1'b0, -1, 8'h00);

    // Boundary patterns, including the parity case 0x07.
    start_req(8'h00);
    frame_check(8'h00, 1'b0, -1, 8'h00);
    start_req(8'hFF);
    frame_check(8'hFF, 1'b0, -1, 8'h00);
    start_req(8'hC3);
    frame_check(8'hC3, 1'b0, -1, 8'h00);
    start_req(8'h07);
    frame_check(8'h07, 1'b0, -1, 8'h00);

    // Random bytes, gaps and mid-frame start attempts.
    for (int r = 0; r < 6; r++) begin
      d     = 8'($urandom);
      idata = 8'($urandom);
      gap   = int'($urandom_range(0, 3));
      intr  = int'($urandom_range(0, FRAME_CYC - 2));
      repeat (gap) @(negedge clk);
      start_req(d);
      frame_check(d, 1'b0, intr, idata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
